uart_tx_cfg: RTL
================

// Module: uart_tx_cfg
// PURPOSE
//  Next-generation UART transmitter with runtime-programmable frame format:
//  baud divisor, data bits (5-9), parity (off/even/odd) and 1 or 2 stop bits.
//  Sits between a CSR block (config) and a byte source (valid/ready) and drives
//  the serial TX pin. Supports gap-free back-to-back frames and optional CTS flow control.
// PARAMETERS
//  DIV_W        16           width of baud divisor; clocks-per-bit range is 2..2**DIV_W-1
//  DATA_W        9           width of i_data; fixed at 9 (the max frame data bits)
//  IDLE_LEVEL    1           line level in idle and stop bits (1 = standard UART)
// PORTS
//  i_clk         in   1       system clock
//  i_rst         in   1       asynchronous, active-high reset
//  i_cfg_div     in   DIV_W   clocks per bit; values 0/1 treated as 2
//  i_cfg_nbits   in   4       data bits per frame; <5 -> 5, >9 -> 9
//  i_cfg_par_en  in   1       1 = parity bit present
//  i_cfg_par_odd in   1       1 = odd parity, 0 = even
//  i_cfg_stop2   in   1       1 = two stop bits
//  i_valid       in   1       source has data on i_data
//  i_data        in   DATA_W  frame data, LSB first; bits >= nbits ignored
//  o_ready       out  1       block accepts i_data this cycle when i_valid=1
//  i_cts_n       in   1       clear-to-send, active low (used only with UART_TX_CTS_EN)
//  o_tx          out  1       serial output
//  o_busy        out  1       frame in progress (any state but IDLE)
//  o_done        out  1       one-cycle pulse on the last clock of the final stop bit
// BEHAVIOUR
//  - Reset (async assert, sync release): o_tx=IDLE_LEVEL, o_ready=1, o_busy=0,
//    o_done=0, state=IDLE, all counters 0, latched config cleared.
//  - Handshake: transfer when i_valid & o_ready; i_data and all i_cfg_* are latched
//    in that cycle and held for the whole frame; cfg changes mid-frame have no effect.
//  - States: IDLE -> START -> DATA -> [PARITY if par_en] -> STOP -> IDLE or START.
//  - Latency: o_tx drives the start bit (~IDLE_LEVEL) on the cycle after the transfer.
//  - Each bit lasts exactly div clocks; baud counter runs 0..div-1, wraps and advances
//    the bit. Bit index counts 0..nbits-1 in DATA; the stop counter counts 1 or 2 bits.
//  - Parity: even = XOR of the nbits data bits; odd = its inverse.
//  - o_ready=1 in IDLE and on the last clock of the final stop bit. A transfer there
//    goes straight to START, so frames are gap-free. o_done pulses on that same clock
//    whether or not a new transfer occurs.
//  - Frame length = div*(1+nbits+par_en+1+stop2) clocks; o_busy high for all of it.
//  - Divisor counter is DIV_W bits; no overflow is possible since the count < div.
//  - Reset mid-frame aborts at once: o_tx returns to IDLE_LEVEL with no o_done pulse.
//  - Unreachable state encodings recover to IDLE with outputs at their reset values.
// CONFIGURATION
//  UART_TX_CTS_EN defined: o_ready is additionally gated by !i_cts_n, so a new
//    frame starts only while CTS is asserted. De-asserting CTS mid-frame never
//    truncates the frame in progress; it only blocks the next one.
//  UART_TX_CTS_EN undefined: i_cts_n is ignored (it should be tied low); no CTS logic
//    is synthesised.
// TESTING
//  1. div=4, nbits=8, no parity, 1 stop, data 0x55 -> o_tx 0,1,0,1,0,1,0,1,0,1,
//     each 4 clks; o_done at clk 40 after the start bit.
//  2. div=3, nbits=7, even parity, data 0x03 -> parity bit 0; with odd parity -> 1;
//     frame = 30 clks.
//  3. nbits=9, 2 stop bits, i_valid held high with 0x1A5 then 0x0F0 -> second start
//     bit on the clock right after the first o_done; no idle gap.
//  4. div=0 and nbits=12 -> behaves as div=2, nbits=9; i_cfg_div changed mid-frame ->
//     frame timing unchanged.
//  5. Assert i_rst in the middle of the DATA state -> o_tx=1, o_busy=0, o_ready=1 at
//     once; the next transfer sends a full, correct frame.
//  6. (UART_TX_CTS_EN) i_cts_n=1 with i_valid=1 -> o_ready=0, o_tx idle; i_cts_n
//     drops -> start bit 1 clk after the transfer; i_cts_n rising mid-frame -> frame completes.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// UART transmitter with a frame format latched per frame (divisor, 5-9 data bits, parity, 1/2 stop); start bit 1 clk after the handshake.
// o_ready only in IDLE or on the final stop clock so frames run gap-free; UART_TX_CTS_EN additionally gates o_ready with !i_cts_n.
module uart_tx_cfg #(
  parameter int   DIV_W      = 16,
  parameter int   DATA_W     = 9,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DIV_W-1:0]  i_cfg_div,
  input  logic [3:0]        i_cfg_nbits,
  input  logic              i_cfg_par_en,
  input  logic              i_cfg_par_odd,
  input  logic              i_cfg_stop2,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  input  logic              i_cts_n,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_TWO = DIV_W'(2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Per-frame configuration, already clamped; parity bit is precomputed at the handshake.
  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [3:0]       nbits;
    logic             par_en;
    logic             stop2;
    logic             par_bit;
  } cfg_t;

  state_t              state_q, state_d;
  cfg_t                cfg_q, cfg_in;
  logic [DATA_W-1:0]   data_q;
  logic [DIV_W-1:0]    baud_cnt;
  logic [3:0]          bit_idx;
  logic                stop_cnt;
  logic                bit_end;
  logic                last_stop;
  logic                cts_ok;
  logic                xfer;

`ifdef UART_TX_CTS_EN
  assign cts_ok = ~i_cts_n;
`else
  logic cts_unused;
  assign cts_unused = i_cts_n;
  assign cts_ok     = 1'b1;
`endif

  assign bit_end   = (baud_cnt == cfg_q.div - DIV_ONE);
  assign last_stop = (state_q == S_STOP) && bit_end && (stop_cnt == cfg_q.stop2);
  assign xfer      = i_valid && o_ready;

  always_comb begin
    cfg_in         = '0;
    cfg_in.div     = (i_cfg_div < DIV_TWO) ? DIV_TWO : i_cfg_div;
    cfg_in.nbits   = (i_cfg_nbits < 4'd5) ? 4'd5 :
                     (i_cfg_nbits > 4'd9) ? 4'd9 : i_cfg_nbits;
    cfg_in.par_en  = i_cfg_par_en;
    cfg_in.stop2   = i_cfg_stop2;
    cfg_in.par_bit = i_cfg_par_odd;
    for (int i = 0; i < DATA_W; i++) begin
      if (4'(i) < cfg_in.nbits) cfg_in.par_bit = cfg_in.par_bit ^ i_data[i];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (xfer) state_d = S_START;
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA:   if (bit_end && (bit_idx == cfg_q.nbits - 4'd1))
                  state_d = cfg_q.par_en ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (last_stop) state_d = xfer ? S_START : S_IDLE;
      default:  state_d = xfer ? S_START : S_IDLE;
    endcase
  end

  always_comb begin
    o_tx    = IDLE_LEVEL;
    o_busy  = 1'b1;
    o_ready = 1'b0;
    o_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_busy  = 1'b0;
        o_ready = cts_ok;
      end
      S_START:  o_tx = ~IDLE_LEVEL;
      S_DATA:   o_tx = data_q[bit_idx];
      S_PARITY: o_tx = cfg_q.par_bit;
      S_STOP: begin
        o_ready = last_stop && cts_ok;
        o_done  = last_stop;
      end
      default: begin
        o_busy  = 1'b0;
        o_ready = cts_ok;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cfg_q    <= '0;
      data_q   <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
    end else if (xfer) begin
      cfg_q    <= cfg_in;
      data_q   <= i_data;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
    end else if (o_busy) begin
      baud_cnt <= bit_end ? '0 : baud_cnt + DIV_ONE;
      if (bit_end && (state_q == S_DATA)) bit_idx  <= bit_idx + 4'd1;
      if (bit_end && (state_q == S_STOP)) stop_cnt <= ~stop_cnt;
      if (state_d == S_IDLE) begin
        bit_idx  <= '0;
        stop_cnt <= 1'b0;
      end
    end
  end

endmodule
